// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter steering a 4:1 mux: one-hot registered grant, hold-timer fairness cap.
// Optional MUX_ARB_LOCK_EN adds a lock input that lets the current owner keep the grant.
module mux4x1_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
`ifdef MUX_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic [DW-1:0]   y,
    output logic            y_valid,
    output logic            busy
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            busy_q, busy_d;
    logic [1:0]      pick;
    logic            own_req;
    logic            lock_hold;

    // First asserted request scanning ptr+1, ptr+2, ptr+3, ptr; the smallest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = p;
        for (int i = 4; i >= 1; i--) begin
            cand = p + 2'(i);
            if (r[cand]) idx = cand;
        end
        return idx;
    endfunction

    assign pick    = rr_pick(req, ptr_q);
    assign own_req = req[sel_q];

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = lock & own_req;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    ptr_d   = pick;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (lock_hold) begin
                    hold_d = hold_q;
                end else if (own_req && (hold_q < HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                end else if (|req) begin
                    // Owner is at ptr, so it is scanned last: another requester wins if present,
                    // otherwise a sole requester whose timer expired is simply re-granted.
                    gnt_d  = 4'b0001 << pick;
                    sel_d  = pick;
                    ptr_d  = pick;
                    hold_d = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    sel_d   = 2'd0;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                sel_d   = 2'd0;
                hold_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign y_valid = |gnt_q;

    always_comb begin
        y = '0;
        if (y_valid) y = din[sel_q*DW +: DW];
    end

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed bench for mux4x1_rr_arbiter (DW=4, MAX_HOLD=4) with hand-computed expectations.
module tb_mux4x1_rr_arbiter;

    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic            lock;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic [DW-1:0]   y;
    logic            y_valid;
    logic            busy;

    int errors = 0;
    int checks = 0;
    logic [3:0] lanes [4];
    logic [3:0] exp_gnt;
    int owner;
    bit  seen;

    always #5 clk = ~clk;

    mux4x1_rr_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
`ifdef MUX_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // din lanes: 0->3, 1->C, 2->5, 3->A
        din = 16'hA5C3;
        lanes[0] = 4'h3; lanes[1] = 4'hC; lanes[2] = 4'h5; lanes[3] = 4'hA;
        rst = 1'b1; req = 4'b0000; lock = 1'b0;
        step();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_busy", busy, 1'b0);

        // 1: idle after reset
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("idle_gnt", gnt, 4'b0000);
        check("idle_sel", sel, 2'd0);
        check("idle_yv", y_valid, 1'b0);
        check("idle_y", y, 4'h0);
        check("idle_busy", busy, 1'b0);

        // 2: sole requester 0, continuous re-grant
        req = 4'b0001;
        step();
        check("t2_gnt", gnt, 4'b0001);
        check("t2_sel", sel, 2'd0);
        check("t2_y", y, 4'h3);
        check("t2_busy", busy, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("t2_nogap", gnt, 4'b0001);
        end
        req = 4'b0000;
        #1;
        check("t2_stale", gnt, 4'b0001);
        step();
        check("t2_drop_gnt", gnt, 4'b0000);
        check("t2_drop_busy", busy, 1'b0);
        check("t2_drop_y", y, 4'h0);

        // 3: all requesting from reset -> 0,1,2,3,0 with 4 cycles each
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step();
            owner   = (c / 4) % 4;
            exp_gnt = 4'b0001 << owner;
            check("t3_gnt", gnt, exp_gnt);
            check("t3_sel", sel, owner);
            check("t3_y", y, lanes[owner]);
        end
        check("t3_wrap", gnt, 4'b0001);

        // 4: owner 2 drops at hold cycle 1, requester 3 takes over; then ptr order gives 0
        do_reset();
        req = 4'b0100;
        step();
        check("t4_own2", gnt, 4'b0100);
        step();
        req = 4'b1000;
        step();
        check("t4_gnt3", gnt, 4'b1000);
        check("t4_sel3", sel, 2'd3);
        check("t4_y3", y, 4'hA);
        req = 4'b0101;
        step();
        check("t4_next0", gnt, 4'b0001);

        // 5: async reset mid-grant, ptr returns to 3
        do_reset();
        req = 4'b0010;
        step();
        check("t5_own1", gnt, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_gnt", gnt, 4'b0000);
        check("t5_async_yv", y_valid, 1'b0);
        check("t5_async_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        req = 4'b1011;
        step();
        check("t5_first0", gnt, 4'b0001);
        check("t5_first0_sel", sel, 2'd0);

`ifdef MUX_ARB_LOCK_EN
        // 6: lock keeps owner 1 indefinitely, release hands over to 2 within MAX_HOLD
        do_reset();
        req = 4'b0010;
        step();
        lock = 1'b1;
        req  = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            step();
            check("t6_locked", gnt, 4'b0010);
        end
        lock = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (gnt == 4'b0100) seen = 1'b1;
        end
        check("t6_unlock", seen, 1'b1);
`endif

        req = 4'b0000;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
